// File: rtl/systolic_matmul_engine.sv
// Output-stationary MAX_DIM x MAX_DIM systolic matrix multiplier with optional bias preload.
// Define MATMUL_SATURATE_EN to clamp overflowing accumulates; otherwise they wrap. Requires MAX_DIM >= 2.
module systolic_matmul_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int MAX_DIM    = 4,
    localparam int DW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  start_i,
    input  logic                                  mode_bit_i,
    input  logic [DW-1:0]                         n_dim_i,
    input  logic [DW-1:0]                         k_dim_i,
    input  logic [DW-1:0]                         m_dim_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] a_matrix_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] b_matrix_i,
    input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]  c_matrix_i,
    output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]  c_matrix_o,
    output logic [MAX_DIM*MAX_DIM-1:0]            flags_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    localparam int TW = $clog2(3*MAX_DIM+1);
    localparam int PW = 2*DATA_WIDTH;
`ifdef MATMUL_SATURATE_EN
    localparam logic signed [BUS_WIDTH-1:0] ACC_MAX = {1'b0, {(BUS_WIDTH-1){1'b1}}};
    localparam logic signed [BUS_WIDTH-1:0] ACC_MIN = {1'b1, {(BUS_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t                                r_state, w_state_nxt;
    logic [TW-1:0]                         r_t;
    logic                                  r_done;
    logic                                  w_last;
    logic [DW-1:0]                         r_n, r_k, r_m;
    logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] r_a, r_b;

    // r_ah[i][j]: a leaving cell (i,j) toward (i,j+1); r_bv[i][j]: b leaving (i,j) toward (i+1,j)
    logic signed [DATA_WIDTH-1:0] r_ah [MAX_DIM][MAX_DIM-1];
    logic signed [DATA_WIDTH-1:0] r_bv [MAX_DIM-1][MAX_DIM];
    logic signed [BUS_WIDTH-1:0]  r_acc [MAX_DIM][MAX_DIM];
    logic                         r_ovf [MAX_DIM][MAX_DIM];

    logic signed [DATA_WIDTH-1:0] w_afeed [MAX_DIM];
    logic signed [DATA_WIDTH-1:0] w_bfeed [MAX_DIM];
    logic signed [DATA_WIDTH-1:0] w_ain [MAX_DIM][MAX_DIM];
    logic signed [DATA_WIDTH-1:0] w_bin [MAX_DIM][MAX_DIM];
    logic signed [BUS_WIDTH-1:0]  w_acc_nxt [MAX_DIM][MAX_DIM];
    logic                         w_of [MAX_DIM][MAX_DIM];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    assign w_last = (r_t == TW'(r_n) + TW'(r_k) + TW'(r_m) + TW'(2));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // done_o is registered off DONE so completion lands Nd+Kd+Md+2 edges after the start edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_t    <= '0;
            r_done <= 1'b0;
            r_n    <= '0;
            r_k    <= '0;
            r_m    <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_RUN) r_t <= r_t + TW'(1);
            else                  r_t <= '0;
            if (r_state == S_LOAD) begin
                r_n <= n_dim_i;
                r_k <= k_dim_i;
                r_m <= m_dim_i;
                r_a <= a_matrix_i;
                r_b <= b_matrix_i;
            end
        end
    end

    // Skewed edge feeds: row i carries A[i][t-i], column j carries B[t-j][j]
    always_comb begin
        for (int unsigned i = 0; i < MAX_DIM; i++) begin
            w_afeed[i] = '0;
            w_bfeed[i] = '0;
            for (int unsigned k = 0; k < MAX_DIM; k++) begin
                if (r_state == S_RUN && r_t == TW'(i + k) && DW'(k) <= r_k) begin
                    if (DW'(i) <= r_n) w_afeed[i] = r_a[(i*MAX_DIM + k)*DATA_WIDTH +: DATA_WIDTH];
                    if (DW'(i) <= r_m) w_bfeed[i] = r_b[(k*MAX_DIM + i)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < MAX_DIM; i++) begin
            w_ain[i][0] = w_afeed[i];
            w_bin[0][i] = w_bfeed[i];
            for (int unsigned j = 1; j < MAX_DIM; j++) begin
                w_ain[i][j] = r_ah[i][j-1];
                w_bin[j][i] = r_bv[j-1][i];
            end
        end
    end

    always_comb begin
        logic signed [PW-1:0]        w_prod;
        logic signed [BUS_WIDTH-1:0] w_pext;
        logic signed [BUS_WIDTH-1:0] w_sum;
        w_prod = '0;
        w_pext = '0;
        w_sum  = '0;
        for (int unsigned i = 0; i < MAX_DIM; i++) begin
            for (int unsigned j = 0; j < MAX_DIM; j++) begin
                w_prod     = PW'(w_ain[i][j]) * PW'(w_bin[i][j]);
                w_pext     = BUS_WIDTH'(w_prod);
                w_sum      = r_acc[i][j] + w_pext;
                w_of[i][j] = (r_acc[i][j][BUS_WIDTH-1] == w_pext[BUS_WIDTH-1]) &&
                             (w_sum[BUS_WIDTH-1] != r_acc[i][j][BUS_WIDTH-1]);
`ifdef MATMUL_SATURATE_EN
                if (w_of[i][j]) w_acc_nxt[i][j] = w_pext[BUS_WIDTH-1] ? ACC_MIN : ACC_MAX;
                else            w_acc_nxt[i][j] = w_sum;
`else
                w_acc_nxt[i][j] = w_sum;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MAX_DIM; i++) begin
                for (int unsigned j = 0; j < MAX_DIM; j++) begin
                    r_acc[i][j] <= '0;
                    r_ovf[i][j] <= 1'b0;
                end
                for (int unsigned j = 0; j + 1 < MAX_DIM; j++) begin
                    r_ah[i][j] <= '0;
                    r_bv[j][i] <= '0;
                end
            end
        end else if (r_state == S_LOAD) begin
            for (int unsigned i = 0; i < MAX_DIM; i++) begin
                for (int unsigned j = 0; j < MAX_DIM; j++) begin
                    r_acc[i][j] <= mode_bit_i ? c_matrix_i[(i*MAX_DIM + j)*BUS_WIDTH +: BUS_WIDTH] : '0;
                    r_ovf[i][j] <= 1'b0;
                end
                for (int unsigned j = 0; j + 1 < MAX_DIM; j++) begin
                    r_ah[i][j] <= '0;
                    r_bv[j][i] <= '0;
                end
            end
        end else if (r_state == S_RUN) begin
            for (int unsigned i = 0; i < MAX_DIM; i++) begin
                for (int unsigned j = 0; j < MAX_DIM; j++) begin
                    r_acc[i][j] <= w_acc_nxt[i][j];
                    r_ovf[i][j] <= r_ovf[i][j] | w_of[i][j];
                end
                for (int unsigned j = 0; j + 1 < MAX_DIM; j++) begin
                    r_ah[i][j] <= w_ain[i][j];
                    r_bv[j][i] <= w_bin[j][i];
                end
            end
        end
    end

    always_comb begin
        c_matrix_o = '0;
        flags_o    = '0;
        for (int unsigned i = 0; i < MAX_DIM; i++) begin
            for (int unsigned j = 0; j < MAX_DIM; j++) begin
                if (DW'(i) <= r_n && DW'(j) <= r_m) begin
                    c_matrix_o[(i*MAX_DIM + j)*BUS_WIDTH +: BUS_WIDTH] = r_acc[i][j];
                    flags_o[i*MAX_DIM + j] = r_ovf[i][j];
                end
            end
        end
    end

    assign busy_o = (r_state != S_IDLE);
    assign done_o = r_done;

endmodule

// File: doc/systolic_matmul_engine.md
SYSTOLIC_MATMUL_ENGINE -- requirements
Module: systolic_matmul_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed operand width of A and B elements.
REQ-002 SHALL have parameter BUS_WIDTH, default 32: signed accumulator/result width; BUS_WIDTH >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter MAX_DIM, default 4: array edge length, independent of BUS_WIDTH; DW = max(1,$clog2(MAX_DIM)).
REQ-004 SHALL have port clk_i input 1: clock, rising edge.
REQ-005 SHALL have port rst_ni input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start_i input 1: operation request, sampled only in IDLE.
REQ-007 SHALL have port mode_bit_i input 1: 0 = C=A*B, 1 = C=A*B+c_matrix_i.
REQ-008 SHALL have ports n_dim_i, k_dim_i, m_dim_i input DW each: dimension minus one (Nd=n_dim_i+1, etc.); A is Nd x Kd, B is Kd x Md.
REQ-009 SHALL have ports a_matrix_i, b_matrix_i input MAX_DIM*MAX_DIM*DATA_WIDTH: element (r,c) at bit offset (r*MAX_DIM+c)*DATA_WIDTH.
REQ-010 SHALL have port c_matrix_i input MAX_DIM*MAX_DIM*BUS_WIDTH: bias, element (r,c) at offset (r*MAX_DIM+c)*BUS_WIDTH.
REQ-011 SHALL have port c_matrix_o output MAX_DIM*MAX_DIM*BUS_WIDTH: result, same packing as c_matrix_i.
REQ-012 SHALL have port flags_o output MAX_DIM*MAX_DIM: overflow flag per element, bit r*MAX_DIM+c.
REQ-013 SHALL have ports busy_o output 1 (high outside IDLE) and done_o output 1 (single-cycle completion pulse).

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-015 IDLE: start_i=1 at a rising edge moves to LOAD; start_i in any other state SHALL be ignored.
REQ-016 LOAD (1 cycle): register A, B, dims and mode; preload each cell accumulator with c_matrix_i element if mode=1, else 0; clear flags_o.
REQ-017 RUN SHALL last exactly Nd+Kd+Md cycles, driven by a step counter t starting at 0.
REQ-018 At step t, row feed i SHALL present A[i][t-i] if 0<=t-i<Kd and i<Nd, else 0; column feed j SHALL present B[t-j][j] if 0<=t-j<Kd and j<Md, else 0.
REQ-019 Each cell SHALL forward a right and b down with one-cycle register delay and accumulate the full-precision signed product a*b sign-extended to BUS_WIDTH.
REQ-020 Cells with r>=Nd or c>=Md SHALL output 0 on c_matrix_o and 0 on flags_o.
REQ-021 DONE (1 cycle): done_o=1; next state IDLE.
REQ-022 done_o SHALL rise exactly Nd+Kd+Md+2 cycles after the edge that sampled start_i.
REQ-023 c_matrix_o SHALL hold the final result from DONE until the next LOAD; it is not valid during LOAD/RUN.
REQ-024 Overflow: flags_o bit SHALL set when a signed BUS_WIDTH accumulate (incl. preload+product) overflows, and SHALL stay set until the next LOAD.
REQ-025 start_i held high continuously SHALL start a new operation on the cycle after DONE (back-to-back, one IDLE cycle between).

Reset
REQ-026 On rst_ni=0, state SHALL go to IDLE immediately; counter, feeds, accumulators, c_matrix_o, flags_o SHALL clear to 0; busy_o=0, done_o=0.
REQ-027 Reset asserted mid-RUN SHALL abort with no done_o pulse; the first start_i after release starts cleanly.

Configuration
REQ-028 Macro MATMUL_SATURATE_EN defined: an overflowing accumulate SHALL clamp to the signed BUS_WIDTH max/min and set the flag.
REQ-029 MATMUL_SATURATE_EN undefined: an overflowing accumulate SHALL wrap modulo 2^BUS_WIDTH and set the flag.

Verification
REQ-030 Defaults, mode 0, 4x4 A=identity, B[r][c]=r*4+c -> c_matrix_o equals B; done_o after 14 cycles; flags_o=0.
REQ-031 Dims 2x3 * 3x1 (n=1,k=2,m=0), A=[[1,2,3],[4,5,6]], B=[7,8,9]^T -> C[0][0]=50, C[1][0]=122, all other elements 0; done_o after 8 cycles.
REQ-032 Mode 1, 1x1x1, A=-3, B=5, C_in=10 -> result -5; start_i pulsed in RUN is ignored (single done_o).
REQ-033 DATA_WIDTH=8, BUS_WIDTH=16, mode 1, C_in=32767, A=B=1 (1x1x1) -> flag set; result 32767 with MATMUL_SATURATE_EN, -32768 without.
REQ-034 rst_ni low at RUN step 3 -> all outputs 0 immediately, no done_o; subsequent 1x1x1 run with A=2, B=3 yields 6.
REQ-035 start_i held high for two runs with 2x2x2 operands -> two done_o pulses 9 cycles apart, each with the correct product.
